// File: rtl/gps_fe_pkg.sv
// Shared sign/magnitude encodings and helpers for the GPS ADC front end.
package gps_fe_pkg;

  localparam int DEF_WIN_LOG2 = 10;

  // Pad format is {sign, magnitude}; sign=1 means negative.
  localparam logic [1:0] SM_POS1 = 2'b00;
  localparam logic [1:0] SM_POS3 = 2'b01;
  localparam logic [1:0] SM_NEG1 = 2'b10;
  localparam logic [1:0] SM_NEG3 = 2'b11;

  function automatic logic signed [2:0] sm_to_signed(input logic [1:0] sm);
    logic signed [2:0] v;
    case (sm)
      SM_POS1: v = 3'sd1;
      SM_POS3: v = 3'sd3;
      SM_NEG1: v = -3'sd1;
      default: v = -3'sd3;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/gps_sync_n.sv
// N-flop single-bit synchroniser with asynchronous active-low clear.
module gps_sync_n #(
  parameter int N = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[N-2:0], d_i};
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/gps_adc_frontend.sv
// ADC pad conditioning: synchronise, map sign/mag to signed values, and run a
// windowed magnitude/sign occupancy monitor per channel.
module gps_adc_frontend
  import gps_fe_pkg::*;
#(
  parameter int WIN_LOG2    = DEF_WIN_LOG2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                mclk,
  input  logic                mclr,
  input  logic [1:0]          adc_i_raw,
  input  logic [1:0]          adc_q_raw,
  input  logic                select_qmaxim,
  input  logic                en,
  output logic [1:0]          adc2bit_i,
  output logic [1:0]          adc2bit_q,
  output logic signed [2:0]   i_val,
  output logic signed [2:0]   q_val,
  output logic                sample_valid,
  output logic [WIN_LOG2:0]   mag_cnt_i,
  output logic [WIN_LOG2:0]   mag_cnt_q,
  output logic [WIN_LOG2:0]   pos_cnt_i,
  output logic [WIN_LOG2:0]   pos_cnt_q,
  output logic                mon_valid
);

  localparam int CW = WIN_LOG2 + 1;

  logic [5:0] pad_raw, pad_s;
  logic [1:0] i_s, q_s;
  logic       sel_s, en_s;

  assign pad_raw = {en, select_qmaxim, adc_q_raw, adc_i_raw};

  for (genvar g = 0; g < 6; g++) begin : g_sync
    gps_sync_n #(.N(SYNC_STAGES)) u_sync (
      .clk_i  (mclk),
      .rst_ni (mclr),
      .d_i    (pad_raw[g]),
      .q_o    (pad_s[g])
    );
  end

  assign i_s   = pad_s[1:0];
  assign q_s   = pad_s[3:2];
  assign sel_s = pad_s[4];
  assign en_s  = pad_s[5];

  logic [1:0]          adc_i_q, adc_i_d, adc_q_q, adc_q_d;
  logic signed [2:0]   ival_q, ival_d, qval_q, qval_d;
  logic                valid_q, valid_d, sel_prev_q, sel_prev_d;
  logic [WIN_LOG2-1:0] win_q, win_d;
  logic [CW-1:0]       mag_acc_i_q, mag_acc_i_d, pos_acc_i_q, pos_acc_i_d;
  logic [CW-1:0]       mag_acc_q_q, mag_acc_q_d, pos_acc_q_q, pos_acc_q_d;
  logic [CW-1:0]       mag_cnt_i_q, mag_cnt_i_d, pos_cnt_i_q, pos_cnt_i_d;
  logic [CW-1:0]       mag_cnt_q_q, mag_cnt_q_d, pos_cnt_q_q, pos_cnt_q_d;
  logic [CW-1:0]       mag_sum_i, pos_sum_i, mag_sum_q, pos_sum_q;
  logic                mon_valid_q, mon_valid_d, abort;

  always_comb begin
    adc_i_d    = 2'b00;
    adc_q_d    = 2'b00;
    ival_d     = '0;
    qval_d     = '0;
    valid_d    = en_s;
    sel_prev_d = sel_s;
    if (en_s) begin
      adc_i_d = i_s;
      ival_d  = sm_to_signed(i_s);
      if (sel_s) begin
        adc_q_d = q_s;
        qval_d  = sm_to_signed(q_s);
      end
    end
  end

  // Q contributes nothing in I-only mode so its window totals come out as 0.
  assign mag_sum_i = mag_acc_i_q + CW'(i_s[0]);
  assign pos_sum_i = pos_acc_i_q + CW'(~i_s[1]);
  assign mag_sum_q = mag_acc_q_q + CW'(q_s[0] & sel_s);
  assign pos_sum_q = pos_acc_q_q + CW'(~q_s[1] & sel_s);
  assign abort     = !en_s || (sel_s != sel_prev_q);

  always_comb begin
    win_d       = win_q + 1'b1;
    mag_acc_i_d = mag_sum_i;
    pos_acc_i_d = pos_sum_i;
    mag_acc_q_d = mag_sum_q;
    pos_acc_q_d = pos_sum_q;
    mag_cnt_i_d = mag_cnt_i_q;
    pos_cnt_i_d = pos_cnt_i_q;
    mag_cnt_q_d = mag_cnt_q_q;
    pos_cnt_q_d = pos_cnt_q_q;
    mon_valid_d = 1'b0;
    if (abort || (&win_q)) begin
      win_d       = '0;
      mag_acc_i_d = '0;
      pos_acc_i_d = '0;
      mag_acc_q_d = '0;
      pos_acc_q_d = '0;
    end
    if (!abort && (&win_q)) begin
      mag_cnt_i_d = mag_sum_i;
      pos_cnt_i_d = pos_sum_i;
      mag_cnt_q_d = mag_sum_q;
      pos_cnt_q_d = pos_sum_q;
      mon_valid_d = 1'b1;
    end
  end

  always_ff @(posedge mclk or negedge mclr) begin
    if (!mclr) begin
      adc_i_q     <= '0;
      adc_q_q     <= '0;
      ival_q      <= '0;
      qval_q      <= '0;
      valid_q     <= 1'b0;
      sel_prev_q  <= 1'b0;
      win_q       <= '0;
      mag_acc_i_q <= '0;
      pos_acc_i_q <= '0;
      mag_acc_q_q <= '0;
      pos_acc_q_q <= '0;
      mag_cnt_i_q <= '0;
      pos_cnt_i_q <= '0;
      mag_cnt_q_q <= '0;
      pos_cnt_q_q <= '0;
      mon_valid_q <= 1'b0;
    end else begin
      adc_i_q     <= adc_i_d;
      adc_q_q     <= adc_q_d;
      ival_q      <= ival_d;
      qval_q      <= qval_d;
      valid_q     <= valid_d;
      sel_prev_q  <= sel_prev_d;
      win_q       <= win_d;
      mag_acc_i_q <= mag_acc_i_d;
      pos_acc_i_q <= pos_acc_i_d;
      mag_acc_q_q <= mag_acc_q_d;
      pos_acc_q_q <= pos_acc_q_d;
      mag_cnt_i_q <= mag_cnt_i_d;
      pos_cnt_i_q <= pos_cnt_i_d;
      mag_cnt_q_q <= mag_cnt_q_d;
      pos_cnt_q_q <= pos_cnt_q_d;
      mon_valid_q <= mon_valid_d;
    end
  end

  assign adc2bit_i    = adc_i_q;
  assign adc2bit_q    = adc_q_q;
  assign i_val        = ival_q;
  assign q_val        = qval_q;
  assign sample_valid = valid_q;
  assign mag_cnt_i    = mag_cnt_i_q;
  assign pos_cnt_i    = pos_cnt_i_q;
  assign mag_cnt_q    = mag_cnt_q_q;
  assign pos_cnt_q    = pos_cnt_q_q;
  assign mon_valid    = mon_valid_q;

endmodule

// File: tb/tb_gps_adc_frontend.sv
// Scoreboard bench for gps_adc_frontend with a 16-sample monitor window.
module tb_gps_adc_frontend;

  localparam int WL  = 4;
  localparam int CW  = WL + 1;
  localparam int WIN = 1 << WL;

  logic                mclk;
  logic                mclr;
  logic [1:0]          adc_i_raw, adc_q_raw;
  logic                select_qmaxim, en;
  logic [1:0]          adc2bit_i, adc2bit_q;
  logic signed [2:0]   i_val, q_val;
  logic                sample_valid, mon_valid;
  logic [CW-1:0]       mag_cnt_i, mag_cnt_q, pos_cnt_i, pos_cnt_q;

  gps_adc_frontend #(.WIN_LOG2(WL), .SYNC_STAGES(2)) dut (
    .mclk          (mclk),
    .mclr          (mclr),
    .adc_i_raw     (adc_i_raw),
    .adc_q_raw     (adc_q_raw),
    .select_qmaxim (select_qmaxim),
    .en            (en),
    .adc2bit_i     (adc2bit_i),
    .adc2bit_q     (adc2bit_q),
    .i_val         (i_val),
    .q_val         (q_val),
    .sample_valid  (sample_valid),
    .mag_cnt_i     (mag_cnt_i),
    .mag_cnt_q     (mag_cnt_q),
    .pos_cnt_i     (pos_cnt_i),
    .pos_cnt_q     (pos_cnt_q),
    .mon_valid     (mon_valid)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  typedef struct {
    logic [1:0] a2i;
    logic [1:0] a2q;
    logic [2:0] iv;
    logic [2:0] qv;
    logic       sv;
    logic       mv;
    int         mi;
    int         mq;
    int         pi;
    int         pq;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;

  // Reference window model, tracked at the pad side and aged through sbQ.
  logic mPrevSel;
  int   mWin, mMagI, mMagQ, mPosI, mPosQ;
  int   lastMI, lastMQ, lastPI, lastPQ;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, act, expv);
    end
  endtask

  function automatic logic [2:0] expMap(input logic [1:0] sm);
    case (sm)
      2'b00:   return 3'b001;
      2'b01:   return 3'b011;
      2'b10:   return 3'b111;
      default: return 3'b101;
    endcase
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_a2i"}, {30'd0, adc2bit_i}, 32'd0);
    checkOutput({tag, "_a2q"}, {30'd0, adc2bit_q}, 32'd0);
    checkOutput({tag, "_ival"}, {29'd0, i_val}, 32'd0);
    checkOutput({tag, "_qval"}, {29'd0, q_val}, 32'd0);
    checkOutput({tag, "_valid"}, {31'd0, sample_valid}, 32'd0);
    checkOutput({tag, "_mon"}, {31'd0, mon_valid}, 32'd0);
    checkOutput({tag, "_magi"}, {27'd0, mag_cnt_i}, 32'd0);
    checkOutput({tag, "_posi"}, {27'd0, pos_cnt_i}, 32'd0);
    checkOutput({tag, "_magq"}, {27'd0, mag_cnt_q}, 32'd0);
    checkOutput({tag, "_posq"}, {27'd0, pos_cnt_q}, 32'd0);
  endtask

  // One cycle: compare what the DUT shows now, then drive the next sample.
  task automatic applyStimulus(input logic eV, input logic sV, input logic [1:0] iR, input logic [1:0] qR);
    exp_t ex, nx;
    bit   abortNow;
    if (sbQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL sb_empty: observed 0 entries expected at least 1");
    end else begin
      ex = sbQ.pop_front();
      checkOutput("adc2bit_i", {30'd0, adc2bit_i}, {30'd0, ex.a2i});
      checkOutput("adc2bit_q", {30'd0, adc2bit_q}, {30'd0, ex.a2q});
      checkOutput("i_val", {29'd0, i_val}, {29'd0, ex.iv});
      checkOutput("q_val", {29'd0, q_val}, {29'd0, ex.qv});
      checkOutput("sample_valid", {31'd0, sample_valid}, {31'd0, ex.sv});
      checkOutput("mon_valid", {31'd0, mon_valid}, {31'd0, ex.mv});
      checkOutput("mag_cnt_i", {27'd0, mag_cnt_i}, ex.mi);
      checkOutput("pos_cnt_i", {27'd0, pos_cnt_i}, ex.pi);
      checkOutput("mag_cnt_q", {27'd0, mag_cnt_q}, ex.mq);
      checkOutput("pos_cnt_q", {27'd0, pos_cnt_q}, ex.pq);
    end
    en = eV;
    select_qmaxim = sV;
    adc_i_raw = iR;
    adc_q_raw = qR;
    nx = '{default: 0};
    nx.sv = eV;
    if (eV) begin
      nx.a2i = iR;
      nx.iv  = expMap(iR);
      if (sV) begin
        nx.a2q = qR;
        nx.qv  = expMap(qR);
      end
    end
    abortNow = !eV || (sV != mPrevSel);
    mPrevSel = sV;
    if (abortNow) begin
      mWin = 0; mMagI = 0; mPosI = 0; mMagQ = 0; mPosQ = 0;
    end else begin
      mMagI += int'(iR[0]);
      mPosI += int'(!iR[1]);
      if (sV) begin
        mMagQ += int'(qR[0]);
        mPosQ += int'(!qR[1]);
      end
      mWin++;
      if (mWin == WIN) begin
        lastMI = mMagI; lastPI = mPosI; lastMQ = mMagQ; lastPQ = mPosQ;
        nx.mv = 1'b1;
        mWin = 0; mMagI = 0; mPosI = 0; mMagQ = 0; mPosQ = 0;
      end
    end
    nx.mi = lastMI; nx.pi = lastPI; nx.mq = lastMQ; nx.pq = lastPQ;
    sbQ.push_back(nx);
    @(posedge mclk);
    #1;
  endtask

  task automatic driveN(input int n, input logic eV, input logic sV, input logic [1:0] iR, input logic [1:0] qR);
    for (int k = 0; k < n; k++) applyStimulus(eV, sV, iR, qR);
  endtask

  task automatic doReset();
    exp_t z;
    mclr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      en = 1'($urandom);
      select_qmaxim = 1'($urandom);
      adc_i_raw = 2'($urandom);
      adc_q_raw = 2'($urandom);
      @(posedge mclk);
      #1;
      checkAllZero("rst");
    end
    sbQ.delete();
    mPrevSel = 1'b0;
    mWin = 0; mMagI = 0; mPosI = 0; mMagQ = 0; mPosQ = 0;
    lastMI = 0; lastPI = 0; lastMQ = 0; lastPQ = 0;
    z = '{default: 0};
    repeat (3) sbQ.push_back(z);
    mclr = 1'b1;
  endtask

  initial begin
    mclr = 1'b0;
    en = 1'b0;
    select_qmaxim = 1'b0;
    adc_i_raw = 2'b00;
    adc_q_raw = 2'b00;
    doReset();

    // Mapping sweep; select settles while en is low.
    driveN(3, 1'b0, 1'b1, 2'b00, 2'b00);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) applyStimulus(1'b1, 1'b1, 2'(c), 2'(3 - c));

    // Window: I mag set on 5 samples, sign clear on 9.
    applyStimulus(1'b0, 1'b1, 2'b00, 2'b00);
    for (int k = 0; k < WIN; k++) applyStimulus(1'b1, 1'b1, {k >= 9, k < 5}, 2'(k));
    driveN(2, 1'b1, 1'b1, 2'b00, 2'b00);
    checkOutput("winA_mon", {31'd0, mon_valid}, 32'd1);
    checkOutput("winA_magi", {27'd0, mag_cnt_i}, 32'd5);
    checkOutput("winA_posi", {27'd0, pos_cnt_i}, 32'd9);

    // Full-scale positive window on both channels.
    applyStimulus(1'b0, 1'b1, 2'b00, 2'b00);
    driveN(WIN, 1'b1, 1'b1, 2'b01, 2'b01);
    driveN(2, 1'b1, 1'b1, 2'b00, 2'b00);
    checkOutput("winB_mon", {31'd0, mon_valid}, 32'd1);
    checkOutput("winB_magi", {27'd0, mag_cnt_i}, 32'd16);
    checkOutput("winB_posi", {27'd0, pos_cnt_i}, 32'd16);
    checkOutput("winB_magq", {27'd0, mag_cnt_q}, 32'd16);

    // I-only mode: select change aborts once, then 16 samples close a window.
    for (int k = 0; k < WIN + 1; k++) applyStimulus(1'b1, 1'b0, 2'b00, 2'($urandom));
    driveN(2, 1'b1, 1'b0, 2'b00, 2'b11);
    checkOutput("ionly_mon", {31'd0, mon_valid}, 32'd1);
    checkOutput("ionly_magq", {27'd0, mag_cnt_q}, 32'd0);
    checkOutput("ionly_posq", {27'd0, pos_cnt_q}, 32'd0);
    checkOutput("ionly_posi", {27'd0, pos_cnt_i}, 32'd16);

    // Abort by en after 10 samples, then a full window after re-enable.
    applyStimulus(1'b0, 1'b1, 2'b00, 2'b00);
    driveN(10, 1'b1, 1'b1, 2'b01, 2'b01);
    driveN(4, 1'b0, 1'b1, 2'b01, 2'b01);
    checkOutput("abort_magi", {27'd0, mag_cnt_i}, 32'd0);
    checkOutput("abort_mon", {31'd0, mon_valid}, 32'd0);
    driveN(WIN, 1'b1, 1'b1, 2'b11, 2'b10);
    driveN(2, 1'b1, 1'b1, 2'b00, 2'b00);
    checkOutput("reen_mon", {31'd0, mon_valid}, 32'd1);
    checkOutput("reen_magi", {27'd0, mag_cnt_i}, 32'd16);
    checkOutput("reen_posi", {27'd0, pos_cnt_i}, 32'd0);

    // Select change lands on what would be the last sample: abort wins.
    applyStimulus(1'b0, 1'b1, 2'b00, 2'b00);
    driveN(WIN - 1, 1'b1, 1'b1, 2'b00, 2'b00);
    applyStimulus(1'b1, 1'b0, 2'b00, 2'b00);
    driveN(2, 1'b1, 1'b0, 2'b00, 2'b00);
    checkOutput("simul_mon", {31'd0, mon_valid}, 32'd0);
    checkOutput("simul_posi", {27'd0, pos_cnt_i}, 32'd0);

    // Mid-window select toggle restarts the window.
    driveN(6, 1'b1, 1'b0, 2'b10, 2'b01);
    driveN(WIN + 4, 1'b1, 1'b1, 2'b10, 2'b01);

    // Async reset between edges, mid-window.
    driveN(8, 1'b1, 1'b1, 2'b01, 2'b11);
    #3;
    mclr = 1'b0;
    #1;
    checkAllZero("async");
    doReset();
    driveN(2, 1'b0, 1'b1, 2'b00, 2'b00);
    driveN(WIN, 1'b1, 1'b1, 2'b10, 2'b00);
    driveN(4, 1'b0, 1'b0, 2'b00, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gps_adc_frontend.md
Name: gps_adc_frontend

Overview:
Input conditioning stage between the 2-bit I/Q ADC pads and gps_multichannel.
- Synchronises the raw sign/magnitude pad samples to mclk.
- Maps each sample to signed 3-bit values and delivers aligned 2-bit samples to the correlator engine.
- Runs a windowed signal-level monitor (magnitude and sign occupancy per channel) for front-end gain and DC-bias checks.

Parameters:
- WIN_LOG2, 10: monitor window length = 2^WIN_LOG2 samples (range 2..16).
- SYNC_STAGES, 2: synchroniser depth on pad inputs (2 or 3).

Ports:
- mclk  in  1  sample clock.
- mclr  in  1  asynchronous, active-low reset.
- adc_i_raw  in  2  raw I pad sample; [1]=sign, [0]=magnitude.
- adc_q_raw  in  2  raw Q pad sample, same format.
- select_qmaxim  in  1  1 = Q channel active; 0 = I-only mode.
- en  in  1  front-end enable (static-ish control).
- adc2bit_i  out  2  synchronised I sample to gps_multichannel.
- adc2bit_q  out  2  synchronised Q sample; 2'b00 in I-only mode.
- i_val  out  3  signed I value.
- q_val  out  3  signed Q value.
- sample_valid  out  1  high while outputs carry live samples.
- mag_cnt_i  out  WIN_LOG2+1  I magnitude-bit count, last window.
- mag_cnt_q  out  WIN_LOG2+1  Q magnitude-bit count, last window.
- pos_cnt_i  out  WIN_LOG2+1  I sign=0 count, last window.
- pos_cnt_q  out  WIN_LOG2+1  Q sign=0 count, last window.
- mon_valid  out  1  one-cycle pulse when the counts update.

Behaviour:
- Reset (mclr low, async): all outputs 0, all flops 0, window counter 0.
- Sync: adc_i_raw, adc_q_raw, select_qmaxim and en each pass through SYNC_STAGES flops. The block then has one output register stage.
- Latency: pad value present at edge k appears on adc2bit_*/i_val/q_val after edge k+SYNC_STAGES+1. With the default this is 3 cycles.
- Mapping (sign, mag):
  - 00 -> +1
  - 01 -> +3
  - 10 -> -1
  - 11 -> -3
  - Output is two's complement, 3 bits.
- I-only mode (synced select_qmaxim=0): adc2bit_q=00, q_val=0, mag_cnt_q and pos_cnt_q report 0 at each window end.
- sample_valid = synced en, delayed to align with data. While en=0: adc2bit_*=00, i_val=q_val=0.
- Monitor:
  - Sample counter runs 0..2^WIN_LOG2-1 on each valid sample.
  - The accumulators add the sample's mag bit and (~sign) bit.
  - On the sample where the counter is at max, that sample is included in the count.
  - At the end of the window, the final totals are latched to the *_cnt outputs. The counter and accumulators clear. mon_valid pulses on the next cycle, coincident with the new counts.
  - Counts range 0..2^WIN_LOG2 and never wrap.
- Window abort: deassertion of synced en, or any change of synced select_qmaxim, clears the counter and accumulators that cycle. The *_cnt outputs keep their last values and mon_valid does not pulse. Counting restarts at the next valid sample.
- Simultaneous last-sample and abort: the abort wins, with no latch and no pulse.
- Reset mid-window: everything clears immediately; the first window after release starts fresh.
- First mon_valid after reset or abort comes exactly 2^WIN_LOG2 valid samples later.

Decomposition:
- Package gps_fe_pkg holds:
  - sign/mag encoding constants (SM_POS1, SM_POS3, SM_NEG1, SM_NEG3);
  - the sign/mag-to-signed mapping function;
  - DEF_WIN_LOG2.
- Sub-module gps_sync_n: parameterised N-flop synchroniser with async active-low clear, instantiated per input bit.
- Mapping and monitor stay in the top module.

Test Plan:
- Reset: hold mclr low with random pads -> every output 0; after release, sample_valid rises SYNC_STAGES+1 cycles after en=1.
- Mapping: en=1, select_qmaxim=1, drive adc_i_raw 00,01,10,11 -> i_val 001,011,111,101 three cycles later; adc2bit_i echoes the codes.
- Monitor, WIN_LOG2=4: 16 samples with I pattern mag=1 on 5 samples and sign=0 on 9 -> mag_cnt_i=5, pos_cnt_i=9 with a one-cycle mon_valid. All-01 input -> mag_cnt_i=16, pos_cnt_i=16.
- I-only: select_qmaxim=0 with Q pads toggling -> adc2bit_q=00, q_val=0, Q counts 0 at the next mon_valid.
- Abort: drop en after 10 samples of a 16-sample window -> no mon_valid, counts retain old values. Re-enable -> mon_valid after exactly 16 further samples.
- Mid-window select toggle and async reset mid-window -> window restarts. Reset asserted between edges clears outputs immediately, without waiting for a clock edge.
